// File: rtl/systolic_feeder_5x5_if.sv
// systolic_feeder_5x5_if: beat stream carrying one fmap vector and one weight vector per transfer
interface systolic_feeder_5x5_if #(
  parameter int D_BW = 8,
  parameter int ROWS = 5,
  parameter int COLS = 5
);
  logic                 s_valid;
  logic                 s_ready;
  logic                 s_last;
  logic [D_BW*ROWS-1:0] s_fmap;
  logic [D_BW*COLS-1:0] s_weight;
  modport master (output s_valid, s_last, s_fmap, s_weight, input s_ready);
  modport slave (input s_valid, s_last, s_fmap, s_weight, output s_ready);
endinterface

// File: rtl/systolic_feeder_5x5.sv
// systolic_feeder_5x5: skews fmap/weight beats diagonally into a 5x5 systolic array and generates its enables
module systolic_feeder_5x5 #(
  parameter int D_BW = 8,
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int KW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  systolic_feeder_5x5_if.slave   s,
  output logic [D_BW*ROWS-1:0]   o_fmap,
  output logic [D_BW*COLS-1:0]   o_weight,
  output logic [ROWS+COLS-2:0]   mul_en,
  output logic [ROWS-1:0]        str_en,
  output logic [ROWS*COLS-1:0]   pe_en,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [KW-1:0]          o_k
);
  localparam int NS = ROWS + COLS - 1;
  localparam int DW = $clog2(NS);
  localparam logic [KW-1:0] K_PEN = ~KW'(1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t        state;
  logic [DW-1:0] dcnt;
  logic          acc;
  logic          last;
  assign s.s_ready = !rst && (state == IDLE || state == FEED);
  assign acc       = s.s_valid && s.s_ready;
  // the beat that brings the count to its maximum closes the pass
  assign last      = s.s_last || o_k == K_PEN;
  assign o_busy    = state != IDLE;
  assign str_en    = mul_en[ROWS-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      dcnt   <= '0;
      o_k    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, FEED: if (acc) begin
          o_k   <= o_k + 1'b1;
          dcnt  <= '0;
          state <= last ? DRAIN : FEED;
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == DW'(NS - 1)) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          o_k   <= '0;
        end
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) mul_en <= '0;
    else mul_en <= {mul_en[NS-2:0], acc};
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][D_BW-1:0] d;
    always_ff @(posedge clk or posedge rst)
      if (rst) d <= '0;
      else begin
        d[0] <= acc ? s.s_fmap[r*D_BW +: D_BW] : '0;
        for (int i = 1; i <= r; i++) d[i] <= d[i-1];
      end
    assign o_fmap[r*D_BW +: D_BW] = d[r];
  end
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [c:0][D_BW-1:0] d;
    always_ff @(posedge clk or posedge rst)
      if (rst) d <= '0;
      else begin
        d[0] <= acc ? s.s_weight[c*D_BW +: D_BW] : '0;
        for (int i = 1; i <= c; i++) d[i] <= d[i-1];
      end
    assign o_weight[c*D_BW +: D_BW] = d[c];
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
    for (genvar c = 0; c < COLS; c++) begin : g_pe_c
      assign pe_en[r*COLS+c] = mul_en[r+c];
    end
  end
endmodule
